// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage RV32 pipeline: load-use bubbles, redirect flushes
// and multi-cycle MUL/DIV holds, driving IF/ID and ID/EX stall/flush enables and PC hold.
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W      = 5,
  parameter int LOAD_USE_STALLS = 1,
  parameter int MULDIV_CYCLES   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1_address,
  input  logic [REG_ADDR_W-1:0] id_rs2_address,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd_address,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_muldiv_start,
  input  logic                  ex_branch_taken,
  output logic                  stall_pc,
  output logic                  stall_if_id,
  output logic                  stall_id_ex,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  muldiv_done,
  output logic                  busy
);

  localparam int CNT_MAX = (LOAD_USE_STALLS > MULDIV_CYCLES) ? LOAD_USE_STALLS : MULDIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(LOAD_USE_STALLS - 1);
  localparam logic [CNT_W-1:0] MD_INIT = CNT_W'(MULDIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_STALL = 2'd1,
    MD_BUSY  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             load_use;
  logic             stall_pc_c, stall_if_id_c, stall_id_ex_c;
  logic             flush_if_id_c, flush_id_ex_c, muldiv_done_c;

  // A load to x0 never produces a value, and unread operands cannot depend on it.
  assign load_use = ex_reg_write & ex_mem_read & (ex_rd_address != '0) &
                    ((id_rs1_used & (id_rs1_address == ex_rd_address)) |
                     (id_rs2_used & (id_rs2_address == ex_rd_address)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    stall_pc_c    = 1'b0;
    stall_if_id_c = 1'b0;
    stall_id_ex_c = 1'b0;
    flush_if_id_c = 1'b0;
    flush_id_ex_c = 1'b0;
    muldiv_done_c = 1'b0;
    case (state)
      IDLE: begin
        // A redirect squashes the ID instruction, so it outranks its load-use hazard.
        if (ex_branch_taken) begin
          flush_if_id_c = 1'b1;
          flush_id_ex_c = 1'b1;
        end else if (ex_muldiv_start) begin
          stall_pc_c    = 1'b1;
          stall_if_id_c = 1'b1;
          stall_id_ex_c = 1'b1;
          cnt_next      = MD_INIT;
          state_next    = MD_BUSY;
        end else if (load_use) begin
          stall_pc_c    = 1'b1;
          stall_if_id_c = 1'b1;
          flush_id_ex_c = 1'b1;
          cnt_next      = LD_INIT;
          state_next    = (LD_INIT != '0) ? LD_STALL : IDLE;
        end
      end
      LD_STALL: begin
        stall_pc_c    = 1'b1;
        stall_if_id_c = 1'b1;
        flush_id_ex_c = 1'b1;
        cnt_next      = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_next = IDLE;
      end
      MD_BUSY: begin
        if (cnt == '0) begin
          muldiv_done_c = 1'b1;
          state_next    = IDLE;
        end else begin
          stall_pc_c    = 1'b1;
          stall_if_id_c = 1'b1;
          stall_id_ex_c = 1'b1;
          cnt_next      = cnt - CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are forced low while reset is held, whatever the inputs do.
  assign stall_pc    = rst_n & stall_pc_c;
  assign stall_if_id = rst_n & stall_if_id_c & ~flush_if_id_c;
  assign stall_id_ex = rst_n & stall_id_ex_c & ~flush_id_ex_c;
  assign flush_if_id = rst_n & flush_if_id_c;
  assign flush_id_ex = rst_n & flush_id_ex_c;
  assign muldiv_done = rst_n & muldiv_done_c;
  assign busy        = rst_n & (state != IDLE);

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two configurations driven in parallel, checked every cycle
// against a remaining-cycles model, plus hand-computed directed expectations.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       rs1_used = 1'b0, rs2_used = 1'b0;
  logic       reg_write = 1'b0, mem_read = 1'b0, md_start = 1'b0, br_taken = 1'b0;

  logic [6:0] out_a, out_b;
  int checks = 0;
  int fails  = 0;
  int cycle  = 0;
  bit chk_en = 1'b0;

  // configuration A: 1 load bubble, 4-cycle MUL/DIV; B: 2 bubbles, 5-cycle MUL/DIV
  int ls [2] = '{1, 2};
  int mc [2] = '{4, 5};
  int ld_left [2];
  int md_left [2];

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(1), .MULDIV_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_address(rs1), .id_rs2_address(rs2),
    .id_rs1_used(rs1_used), .id_rs2_used(rs2_used),
    .ex_rd_address(rd), .ex_reg_write(reg_write), .ex_mem_read(mem_read),
    .ex_muldiv_start(md_start), .ex_branch_taken(br_taken),
    .stall_pc(out_a[6]), .stall_if_id(out_a[5]), .stall_id_ex(out_a[4]),
    .flush_if_id(out_a[3]), .flush_id_ex(out_a[2]),
    .muldiv_done(out_a[1]), .busy(out_a[0])
  );

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(2), .MULDIV_CYCLES(5)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_address(rs1), .id_rs2_address(rs2),
    .id_rs1_used(rs1_used), .id_rs2_used(rs2_used),
    .ex_rd_address(rd), .ex_reg_write(reg_write), .ex_mem_read(mem_read),
    .ex_muldiv_start(md_start), .ex_branch_taken(br_taken),
    .stall_pc(out_b[6]), .stall_if_id(out_b[5]), .stall_id_ex(out_b[4]),
    .flush_if_id(out_b[3]), .flush_id_ex(out_b[2]),
    .muldiv_done(out_b[1]), .busy(out_b[0])
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // model: count remaining stall / MUL-DIV cycles; output bits
  // {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, muldiv_done, busy}
  function automatic bit hazard();
    return reg_write && mem_read && rd != 0 &&
           ((rs1_used && rs1 == rd) || (rs2_used && rs2 == rd));
  endfunction

  function automatic logic [6:0] expect_out(int i);
    if (!rst_n) return 7'b0000000;
    if (md_left[i] == 1) return 7'b0000011;
    if (md_left[i] > 1) return 7'b1110001;
    if (ld_left[i] > 0) return 7'b1100101;
    if (br_taken) return 7'b0001100;
    if (md_start) return 7'b1110000;
    if (hazard()) return 7'b1100100;
    return 7'b0000000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        ld_left[i] = 0;
        md_left[i] = 0;
      end else if (md_left[i] > 0) md_left[i] = md_left[i] - 1;
      else if (ld_left[i] > 0) ld_left[i] = ld_left[i] - 1;
      else if (br_taken) ;
      else if (md_start) md_left[i] = mc[i] - 1;
      else if (hazard()) ld_left[i] = ls[i] - 1;
    end
  end

  // scoreboard: every falling edge, expected queue filled from the model
  logic [6:0] exp_q[$];
  always @(negedge clk) begin
    if (chk_en) begin
      logic [6:0] e;
      exp_q.push_back(expect_out(0));
      exp_q.push_back(expect_out(1));
      e = exp_q.pop_front();
      checks++;
      if (out_a !== e) begin
        fails++;
        $display("FAIL model_a cycle %0d: got %b expected %b", cycle, out_a, e);
      end
      e = exp_q.pop_front();
      checks++;
      if (out_b !== e) begin
        fails++;
        $display("FAIL model_b cycle %0d: got %b expected %b", cycle, out_b, e);
      end
    end
  end

  // driver tasks
  task automatic check_lit(string name, logic [6:0] actual, logic [6:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cycle, actual, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1 = '0; rs2 = '0; rd = '0; rs1_used = 0; rs2_used = 0;
    reg_write = 0; mem_read = 0; md_start = 0; br_taken = 0;
  endtask

  task automatic drive_load(logic [4:0] ld_rd, logic [4:0] a1, logic u1, logic [4:0] a2, logic u2);
    clear_inputs();
    rd = ld_rd; reg_write = 1; mem_read = 1;
    rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2;
  endtask

  task automatic drive_random();
    int k;
    clear_inputs();
    k = $urandom_range(0, 9);
    rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    rs1_used = 1'($urandom_range(0, 1)); rs2_used = 1'($urandom_range(0, 1));
    reg_write = 1'($urandom_range(0, 1));
    if (k < 5) begin
      mem_read = 1; reg_write = ($urandom_range(0, 7) != 0);
    end else if (k == 5) md_start = 1;
    else if (k == 6) begin
      br_taken = 1; mem_read = 1'($urandom_range(0, 1));
    end
    rst_n = ($urandom_range(0, 199) != 0);
  endtask

  initial begin
    // reset: outputs low even with a redirect on the inputs
    br_taken = 1;
    chk_en = 1;
    @(negedge clk);
    check_lit("reset_a", out_a, 7'b0000000);
    check_lit("reset_b", out_b, 7'b0000000);
    next_cycle();
    rst_n = 1;
    clear_inputs();
    next_cycle();

    // lw x5 ; add x6,x5,x1
    drive_load(5'd5, 5'd5, 1, 5'd1, 1);
    @(negedge clk);
    check_lit("lu1_a", out_a, 7'b1100100);
    check_lit("lu1_b", out_b, 7'b1100100);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check_lit("lu2_a", out_a, 7'b0000000);
    check_lit("lu2_b", out_b, 7'b1100101);
    next_cycle();
    @(negedge clk);
    check_lit("lu3_b", out_b, 7'b0000000);
    next_cycle();

    // rd==x0 load, and matching but unused rs2: no hazard
    drive_load(5'd0, 5'd0, 1, 5'd0, 1);
    @(negedge clk);
    check_lit("x0_a", out_a, 7'b0000000);
    check_lit("x0_b", out_b, 7'b0000000);
    next_cycle();
    drive_load(5'd5, 5'd3, 1, 5'd5, 0);
    @(negedge clk);
    check_lit("unused_a", out_a, 7'b0000000);
    next_cycle();

    // MUL/DIV on A: stalls t..t+2, done only at t+3
    clear_inputs();
    md_start = 1;
    @(negedge clk);
    check_lit("md_t0", out_a, 7'b1110000);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check_lit("md_t1", out_a, 7'b1110001);
    next_cycle();
    @(negedge clk);
    check_lit("md_t2", out_a, 7'b1110001);
    next_cycle();
    @(negedge clk);
    check_lit("md_t3", out_a, 7'b0000011);
    next_cycle();
    @(negedge clk);
    check_lit("md_t4", out_a, 7'b0000000);
    repeat (3) next_cycle();

    // redirect together with load-use: flushes only
    drive_load(5'd7, 5'd7, 1, 5'd0, 0);
    br_taken = 1;
    @(negedge clk);
    check_lit("br_lu_a", out_a, 7'b0001100);
    check_lit("br_lu_b", out_b, 7'b0001100);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check_lit("br_after_a", out_a, 7'b0000000);
    next_cycle();

    // reset during MUL/DIV on A with one stall cycle left
    md_start = 1;
    next_cycle();
    clear_inputs();
    next_cycle();
    rst_n = 0;
    @(negedge clk);
    check_lit("rst_md_a", out_a, 7'b0000000);
    check_lit("rst_md_b", out_b, 7'b0000000);
    next_cycle();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_lit("rst_md_idle_a", out_a, 7'b0000000);
      next_cycle();
    end

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      next_cycle();
    end
    rst_n = 1;
    clear_inputs();
    repeat (8) next_cycle();

    @(negedge clk);
    chk_en = 0;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
